// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants: op kinds, opcode fields, immediate limits
// and the FSM state type used by the instruction encoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_ADDI = 4'd4,
        OP_LDUR = 4'd5,
        OP_STUR = 4'd6,
        OP_CBZ  = 4'd7,
        OP_CBNZ = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FULL
    } state_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

    // Immediates are carried as 19-bit two's complement on the descriptor bus.
    localparam logic signed [18:0] ADDI_IMM_MIN = 19'sd0;
    localparam logic signed [18:0] ADDI_IMM_MAX = 19'sd4095;
    localparam logic signed [18:0] DT_IMM_MIN   = -19'sd256;
    localparam logic signed [18:0] DT_IMM_MAX   = 19'sd255;

    function automatic logic imm_in_range(input logic signed [18:0] value,
                                          input logic signed [18:0] lo,
                                          input logic signed [18:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational LEGv8 packer: turns an op descriptor into a 32-bit word and
// flags whether the op kind and immediate are encodable.
module instr_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic signed [18:0] simm;

    assign simm = $signed(imm);

    // For LDUR/STUR/CBZ/CBNZ the rd field carries Rt.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_ADD: begin
                word  = {OPC_ADD, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_SUB: begin
                word  = {OPC_SUB, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_AND: begin
                word  = {OPC_AND, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_ORR: begin
                word  = {OPC_ORR, rm, 6'b000000, rn, rd};
                legal = 1'b1;
            end
            OP_ADDI: begin
                word  = {OPC_ADDI, imm[11:0], rn, rd};
                legal = imm_in_range(simm, ADDI_IMM_MIN, ADDI_IMM_MAX);
            end
            OP_LDUR: begin
                word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                legal = imm_in_range(simm, DT_IMM_MIN, DT_IMM_MAX);
            end
            OP_STUR: begin
                word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                legal = imm_in_range(simm, DT_IMM_MIN, DT_IMM_MAX);
            end
            OP_CBZ: begin
                word  = {OPC_CBZ, imm, rd};
                legal = 1'b1;
            end
            OP_CBNZ: begin
                word  = {OPC_CBNZ, imm, rd};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction encoder: accepts op descriptors, packs them into
// LEGv8 words and streams them to instruction memory at consecutive addresses.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_op,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rn,
    input  logic [4:0]                  in_rm,
    input  logic [18:0]                 in_imm,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [63:0]                 wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        busy,
    output logic                        full,
    output logic                        err,
    output logic [$clog2(IMEM_WORDS):0] count
);

    localparam int CW = $clog2(IMEM_WORDS) + 1;

    state_e        state;
    state_e        state_next;
    logic          session_open;
    logic [31:0]   pack_word;
    logic          pack_legal;
    logic          wr_fire;
    logic          accept;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count_inc;

    instr_pack u_pack (
        .op    (in_op),
        .rd    (in_rd),
        .rn    (in_rn),
        .rm    (in_rm),
        .imm   (in_imm),
        .word  (pack_word),
        .legal (pack_legal)
    );

    assign wr_fire   = wr_valid && wr_ready;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + CW'(1);

    // A word still sitting in the output register already claims a memory slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, wr_valid};
    assign in_ready  = (state == ST_RUN) && (!wr_valid || wr_ready)
                       && (occupancy < (CW + 1)'(IMEM_WORDS));

    // The write address is simply the session word count scaled to bytes.
    assign wr_addr = {{(62 - CW){1'b0}}, count, 2'b00};
    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign full    = (count == CW'(IMEM_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop outranks start; an accepted descriptor in the stop cycle drains later.
    always_comb begin
        state_next   = state;
        session_open = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next   = ST_RUN;
                    session_open = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_DRAIN;
                end else if (wr_fire && (count_inc == CW'(IMEM_WORDS))) begin
                    state_next = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (!wr_valid || wr_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (start) begin
                    state_next   = ST_RUN;
                    session_open = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output word register, session counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (session_open) begin
            wr_valid <= 1'b0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (wr_fire) begin
                count <= count_inc;
            end
            if (accept && pack_legal) begin
                wr_valid <= 1'b1;
                wr_data  <= pack_word;
            end else if (wr_fire) begin
                wr_valid <= 1'b0;
            end
            if (accept && !pack_legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by a
// randomized phase, all compared against a behavioural session model.
module tb_instr_encoder;

    localparam int N = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_FULL  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [18:0] in_imm;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        full;
    logic        err;
    logic [$clog2(N):0] count;

    int total = 0;
    int bad   = 0;

    int d_op, d_rd, d_rn, d_rm, d_imm;

    int          m_st      = S_IDLE;
    bit          m_pend    = 1'b0;
    int          m_written = 0;
    bit          m_err     = 1'b0;
    logic [31:0] m_data    = '0;

    instr_encoder #(.IMEM_WORDS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rn    (in_rn),
        .in_rm    (in_rm),
        .in_imm   (in_imm),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .full     (full),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from the architectural field layout with integer arithmetic.
    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rn,
                                               input int rm, input int imm, output bit ok);
        logic [31:0] w;
        int          regs;
        regs = rn * 32 + rd;
        ok   = 1'b0;
        w    = 32'h0;
        case (op)
            0: begin ok = 1'b1; w = 32'h8B000000 + 32'(rm * 65536 + regs); end
            1: begin ok = 1'b1; w = 32'hCB000000 + 32'(rm * 65536 + regs); end
            2: begin ok = 1'b1; w = 32'h8A000000 + 32'(rm * 65536 + regs); end
            3: begin ok = 1'b1; w = 32'hAA000000 + 32'(rm * 65536 + regs); end
            4: begin
                ok = (imm >= 0) && (imm <= 4095);
                w  = 32'h91000000 + 32'((imm & 4095) * 1024 + regs);
            end
            5: begin
                ok = (imm >= -256) && (imm <= 255);
                w  = 32'hF8400000 + 32'((((imm % 512) + 512) % 512) * 4096 + regs);
            end
            6: begin
                ok = (imm >= -256) && (imm <= 255);
                w  = 32'hF8000000 + 32'((((imm % 512) + 512) % 512) * 4096 + regs);
            end
            7: begin ok = 1'b1; w = 32'hB4000000 + 32'((((imm % 524288) + 524288) % 524288) * 32 + rd); end
            8: begin ok = 1'b1; w = 32'hB5000000 + 32'((((imm % 524288) + 524288) % 524288) * 32 + rd); end
            default: begin ok = 1'b0; w = 32'h0; end
        endcase
        return w;
    endfunction

    function automatic bit model_in_ready();
        return (m_st == S_RUN) && (!m_pend || wr_ready) && ((m_written + int'(m_pend)) < N);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input int op, input int rd, input int rn, input int rm, input int imm);
        d_op = op; d_rd = rd; d_rn = rn; d_rm = rm; d_imm = imm;
        in_op  = 4'(op);
        in_rd  = 5'(rd);
        in_rn  = 5'(rn);
        in_rm  = 5'(rm);
        in_imm = 19'(imm);
    endtask

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic applyStimulus();
        bit          fire, acc, ok, start_ok, old_pend;
        logic [31:0] w;
        #1;
        checkOutput("in_ready", in_ready, model_in_ready());
        checkOutput("wr_valid", wr_valid, m_pend);
        if (m_pend) begin
            checkOutput("wr_addr", wr_addr, 64'(m_written * 4));
            checkOutput("wr_data", wr_data, m_data);
        end
        checkOutput("count", count, 64'(m_written));
        checkOutput("err", err, m_err);
        checkOutput("busy", busy, (m_st == S_RUN) || (m_st == S_DRAIN));
        checkOutput("full", full, m_written == N);

        old_pend = m_pend;
        fire     = m_pend && wr_ready;
        acc      = in_valid && model_in_ready();
        if (reset) begin
            m_st = S_IDLE; m_pend = 1'b0; m_written = 0; m_err = 1'b0;
        end else begin
            start_ok = start && !stop && ((m_st == S_IDLE) || (m_st == S_FULL));
            if (fire) begin
                m_written++;
                m_pend = 1'b0;
            end
            if (acc) begin
                w = ref_encode(d_op, d_rd, d_rn, d_rm, d_imm, ok);
                if (ok) begin
                    m_pend = 1'b1;
                    m_data = w;
                end else begin
                    m_err = 1'b1;
                end
            end
            case (m_st)
                S_IDLE:  if (start_ok) begin m_st = S_RUN; m_written = 0; m_err = 1'b0; end
                S_RUN:   if (stop) m_st = S_DRAIN; else if (m_written == N) m_st = S_FULL;
                S_DRAIN: if (!old_pend || fire) m_st = S_IDLE;
                default: begin
                    if (stop) m_st = S_IDLE;
                    else if (start_ok) begin m_st = S_RUN; m_written = 0; m_err = 1'b0; end
                end
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
        set_desc(0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus();
        checkOutput("rst_wr_addr", wr_addr, 64'h0);
        checkOutput("rst_wr_data", wr_data, 64'h0);
        reset = 1'b0;
        applyStimulus();

        // ADD x1, x2, x3 appears one cycle after acceptance at address 0.
        start = 1'b1; applyStimulus(); start = 1'b0;
        set_desc(0, 1, 2, 3, 0); in_valid = 1'b1;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("add_valid", wr_valid, 1'b1);
        checkOutput("add_data", wr_data, 64'h8B030041);
        checkOutput("add_addr", wr_addr, 64'h0);
        applyStimulus();
        checkOutput("add_count", count, 64'd1);

        // Out-of-range immediates are swallowed and flag err; CBZ then lands at 0.
        stop = 1'b1; applyStimulus(); stop = 1'b0;
        applyStimulus();
        start = 1'b1; applyStimulus(); start = 1'b0;
        in_valid = 1'b1;
        set_desc(4, 1, 1, 0, 4096); applyStimulus();
        set_desc(5, 2, 3, 0, -257); applyStimulus();
        in_valid = 1'b0;
        checkOutput("illegal_err", err, 1'b1);
        checkOutput("illegal_count", count, 64'd0);
        checkOutput("illegal_nowrite", wr_valid, 1'b0);
        set_desc(7, 5, 0, 0, -1); in_valid = 1'b1; applyStimulus(); in_valid = 1'b0;
        checkOutput("cbz_data", wr_data, 64'hB4FFFFE5);
        checkOutput("cbz_addr", wr_addr, 64'h0);
        applyStimulus();

        // Backpressure: a pending SUB must hold while the next AND waits.
        wr_ready = 1'b0;
        set_desc(1, 7, 8, 9, 0); in_valid = 1'b1; applyStimulus();
        set_desc(2, 10, 11, 12, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stall_data", wr_data, 64'hCB090107);
        end
        wr_ready = 1'b1; applyStimulus();
        in_valid = 1'b0; applyStimulus();
        applyStimulus();

        // Fill a fresh session with STURs; only four fit.
        stop = 1'b1; applyStimulus(); stop = 1'b0;
        applyStimulus();
        start = 1'b1; applyStimulus(); start = 1'b0;
        set_desc(12, 0, 0, 0, 0); in_valid = 1'b1; applyStimulus();
        for (int i = 0; i < 6; i++) begin
            set_desc(6, i, i + 1, 0, i * 8 - 20);
            applyStimulus();
        end
        in_valid = 1'b0; applyStimulus();
        checkOutput("fill_full", full, 1'b1);
        checkOutput("fill_in_ready", in_ready, 1'b0);
        checkOutput("fill_count", count, 64'd4);
        start = 1'b1; applyStimulus(); start = 1'b0;
        checkOutput("restart_count", count, 64'd0);
        checkOutput("restart_err", err, 1'b0);

        // ORR accepted together with stop still drains out.
        set_desc(3, 3, 4, 5, 0); in_valid = 1'b1; stop = 1'b1; applyStimulus();
        in_valid = 1'b0; stop = 1'b0;
        checkOutput("orr_data", wr_data, 64'hAA050083);
        checkOutput("orr_busy", busy, 1'b1);
        applyStimulus();
        checkOutput("orr_idle", busy, 1'b0);

        // Reset while a write is stalled.
        start = 1'b1; applyStimulus(); start = 1'b0;
        wr_ready = 1'b0; set_desc(0, 9, 9, 9, 0); in_valid = 1'b1; applyStimulus();
        in_valid = 1'b0; applyStimulus();
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        checkOutput("rst2_wr_valid", wr_valid, 1'b0);
        checkOutput("rst2_wr_addr", wr_addr, 64'h0);
        checkOutput("rst2_wr_data", wr_data, 64'h0);
        checkOutput("rst2_count", count, 64'd0);
        wr_ready = 1'b1; applyStimulus();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int imm;
            case ($urandom_range(0, 2))
                0:       imm = int'($urandom_range(0, 4200));
                1:       imm = int'($urandom_range(0, 600)) - 300;
                default: imm = int'($urandom_range(0, 524287)) - 262144;
            endcase
            set_desc(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
            in_valid = ($urandom_range(0, 9) < 6);
            wr_ready = ($urandom_range(0, 9) < 7);
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            applyStimulus();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: IMEM_WORDS, 64, instruction-memory capacity in 32-bit words (power of two, 4..1024).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; opens an encode session at word address 0.
REQ-005 stop  in  1  one-cycle pulse; closes the session after the pending write drains.
REQ-006 in_valid  in  1  an op descriptor is presented.
REQ-007 in_ready  out  1  descriptor accepted on the cycle where in_valid and in_ready are both 1.
REQ-008 in_op  in  4  op kind: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 LDUR, 6 STUR, 7 CBZ, 8 CBNZ; 9..15 illegal.
REQ-009 in_rd, in_rn, in_rm  in  5 each  register fields (Rt = in_rd for LDUR/STUR/CBZ/CBNZ).
REQ-010 in_imm  in  19  signed immediate / branch offset in words.
REQ-011 wr_valid  out  1  wr_addr/wr_data hold a word to write.
REQ-012 wr_ready  in  1  memory accepts the word when wr_valid and wr_ready are both 1.
REQ-013 wr_addr  out  64  byte address (word index x 4).
REQ-014 wr_data  out  32  encoded LEGv8 instruction.
REQ-015 busy  out  1  state is RUN or DRAIN.
REQ-016 full  out  1  IMEM_WORDS words written in this session.
REQ-017 err  out  1  sticky; set on any rejected descriptor, cleared by start or reset.
REQ-018 count  out  $clog2(IMEM_WORDS)+1  words written in this session.

Function
REQ-019 Encodings: R-type {opc11, Rm, 6'b0, Rn, Rd}; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-020 ADDI: {10'b1001000100, imm[11:0], Rn, Rd}; legal only for in_imm 0..4095.
REQ-021 LDUR {11111000010, imm[8:0], 2'b00, Rn, Rt}, STUR {11111000000, ...}; legal only for in_imm -256..255.
REQ-022 CBZ {8'b10110100, imm[18:0], Rt}, CBNZ {8'b10110101, ...}; every 19-bit value legal.
REQ-023 Illegal op or out-of-range immediate: descriptor consumed, no word written, count unchanged, err set next cycle.
REQ-024 States IDLE, RUN, DRAIN, FULL; IDLE --start--> RUN; RUN --stop--> DRAIN; RUN --count reaches IMEM_WORDS--> FULL; DRAIN --no word pending--> IDLE; FULL --stop--> IDLE; FULL --start--> RUN.
REQ-025 in_ready = 1 only in RUN and (wr_valid = 0 or wr_ready = 1) and (count + pending word) < IMEM_WORDS.
REQ-026 Latency: a legal descriptor accepted in cycle N gives wr_valid = 1 in cycle N+1; full throughput of one word per cycle when wr_ready is held at 1.
REQ-027 wr_valid, wr_addr and wr_data are held stable while wr_valid = 1 and wr_ready = 0.
REQ-028 Address counter starts at 0 on start and increments by 4 per completed write; count increments on the same event.
REQ-029 start outside IDLE/FULL is ignored; stop in IDLE is ignored; start and stop in the same cycle: stop wins.
REQ-030 stop with a descriptor accepted in the same cycle: that descriptor is still encoded and written in DRAIN.

Reset
REQ-031 Reset gives state IDLE, in_ready 0, wr_valid 0, wr_addr 0, wr_data 0, busy 0, full 0, err 0, count 0.
REQ-032 Reset mid-write drops the pending word; memory sees no further wr_valid.

Structure
REQ-033 Opcode constants, op-kind enum and immediate-range limits SHALL live in shared package legv8_pkg; the decoder SHALL use the same constants.
REQ-034 Packing and range checking SHALL be a combinational sub-module instr_pack (op, regs, imm -> word, legal); all sequencing lives in instr_encoder.

Verification
REQ-035 Send start, then ADD rd=1 rn=2 rm=3 with wr_ready=1 -> 0x8B030041 at wr_addr 0 one cycle after acceptance; count=1.
REQ-036 Send ADDI imm=4096, then LDUR imm=-257 -> no writes, err=1, count=0; then CBZ rt=5 imm=-1 -> 0xB4FFFFE5 at address 0.
REQ-037 Hold wr_ready=0 for 5 cycles with a word pending -> wr_* stable and in_ready=0; release -> one write, then the next word follows.
REQ-038 IMEM_WORDS=4, stream 6 STUR -> 4 writes at addresses 0,4,8,12; full=1 and in_ready=0 after the 4th; start restarts at 0 with err cleared.
REQ-039 stop in the same cycle as accepting ORR -> ORR written in DRAIN, then IDLE with busy=0; assert reset during a stalled write -> all outputs reach reset values on the next edge.
